// File: rtl/pipe_mem_arbiter.sv
// Single-port arbiter that shares one 1024x32 memory between instruction fetch (I),
// MEM-stage load/store (D) and the halted-core loader (L), and routes read data back to the requester.
module pipe_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          halted,

  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,

  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic [3:0]    starve_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_L    = 2'd3
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  owner_t     r_owner;

  logic       w_i_elig;
  logic       w_d_elig;
  logic       w_l_elig;
  logic       w_starved;
  logic       w_i_gnt;
  logic       w_d_gnt;
  logic       w_l_gnt;
  owner_t     w_owner_next;
  logic [3:0] w_starve_next;

  // Reset masks every grant so nothing touches memory while the core is being reset.
  assign w_i_elig  = i_req & ~halted & ~rst;
  assign w_d_elig  = d_req & ~halted & ~rst;
  assign w_l_elig  = l_req &  halted & ~rst;
  assign w_starved = (r_starve_cnt >= STARVE_LIM);

  assign w_i_gnt = w_i_elig & (~w_d_elig | w_starved);
  assign w_d_gnt = w_d_elig & ~w_i_gnt;
  assign w_l_gnt = w_l_elig;

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;
  assign l_gnt = w_l_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
    end else if (w_d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_l_gnt) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (halted) begin
      w_starve_next = r_starve_cnt;
    end else if (!i_req || w_i_gnt) begin
      w_starve_next = 4'd0;
    end else if (r_starve_cnt != 4'd15) begin
      w_starve_next = r_starve_cnt + 4'd1;
    end
  end

  // Only reads claim the return slot; writes leave it empty.
  always_comb begin
    w_owner_next = OWN_NONE;
    if (w_i_gnt) begin
      w_owner_next = OWN_I;
    end else if (w_d_gnt && !d_we) begin
      w_owner_next = OWN_D;
    end else if (w_l_gnt && !l_we) begin
      w_owner_next = OWN_L;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
      r_owner      <= OWN_NONE;
    end else begin
      r_starve_cnt <= w_starve_next;
      r_owner      <= w_owner_next;
    end
  end

  assign starve_cnt = r_starve_cnt;

  // A read in flight when reset arrives is dropped in the same cycle.
  assign i_rvalid = (r_owner == OWN_I) & ~rst;
  assign d_rvalid = (r_owner == OWN_D) & ~rst;
  assign l_rvalid = (r_owner == OWN_L) & ~rst;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign l_rdata = mem_rdata;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: a behavioural 1-cycle memory plus a linear list of
// steps with hand-computed expectations, checked by immediate assertions.
module tb_pipe_mem_arbiter;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        halted;
  logic        i_req, d_req, d_we, l_req, l_we;
  logic [9:0]  i_addr, d_addr, l_addr;
  logic [31:0] d_wdata, l_wdata;
  logic        i_gnt, d_gnt, l_gnt;
  logic        i_rvalid, d_rvalid, l_rvalid;
  logic [31:0] i_rdata, d_rdata, l_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  starve_cnt;

  logic [31:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  always #5 clk1 = ~clk1;

  pipe_mem_arbiter #(.AW(10), .DW(32), .STARVE_MAX(4)) dut (
    .clk1(clk1), .rst(rst), .halted(halted),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  // Memory model; contents are (re)loaded whenever reset is held.
  always @(posedge clk1) begin
    if (rst) begin
      mem[3] <= 32'h0000_3333;
      mem[5] <= 32'h2801_000A;
      mem[7] <= 32'h1111_0007;
      mem[8] <= 32'h2222_0008;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; l_req = 1'b0;
    d_we  = 1'b0; l_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    int exp_ig  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    rst = 1'b1; halted = 1'b0;
    idle();
    i_addr = '0; d_addr = '0; l_addr = '0; d_wdata = '0; l_wdata = '0;
    @(negedge clk1);
    // Requests during reset must not be granted
    @(negedge clk1);
    i_req = 1'b1; d_req = 1'b1;
    #1;
    chk("rst_i_gnt", 32'(i_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);

    @(negedge clk1);
    rst = 1'b0; idle();
    #1;
    chk("reset_starve", 32'(starve_cnt), 0);
    chk("reset_i_rvalid", 32'(i_rvalid), 0);
    chk("reset_d_rvalid", 32'(d_rvalid), 0);
    chk("reset_l_rvalid", 32'(l_rvalid), 0);

    // Basic fetch
    @(negedge clk1);
    i_req = 1'b1; i_addr = 10'd5;
    #1;
    chk("fetch_i_gnt", 32'(i_gnt), 1);
    chk("fetch_mem_en", 32'(mem_en), 1);
    chk("fetch_mem_we", 32'(mem_we), 0);
    chk("fetch_mem_addr", 32'(mem_addr), 5);
    @(negedge clk1);
    idle();
    #1;
    chk("fetch_i_rvalid", 32'(i_rvalid), 1);
    chk("fetch_i_rdata", i_rdata, 32'h2801_000A);
    chk("fetch_d_rvalid", 32'(d_rvalid), 0);

    // Store beats fetch, fetch follows next cycle
    @(negedge clk1);
    i_req = 1'b1; i_addr = 10'd3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd20; d_wdata = 32'h55;
    #1;
    chk("conf_d_gnt", 32'(d_gnt), 1);
    chk("conf_i_gnt", 32'(i_gnt), 0);
    chk("conf_mem_we", 32'(mem_we), 1);
    chk("conf_mem_addr", 32'(mem_addr), 20);
    chk("conf_mem_wdata", mem_wdata, 32'h55);
    @(negedge clk1);
    d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("conf2_i_gnt", 32'(i_gnt), 1);
    chk("conf2_mem_addr", 32'(mem_addr), 3);
    chk("conf2_starve", 32'(starve_cnt), 1);
    chk("conf2_d_rvalid", 32'(d_rvalid), 0);
    chk("conf2_i_rvalid", 32'(i_rvalid), 0);
    @(negedge clk1);
    idle();
    #1;
    chk("conf3_i_rvalid", 32'(i_rvalid), 1);
    chk("conf3_i_rdata", i_rdata, 32'h0000_3333);
    chk("conf3_starve", 32'(starve_cnt), 0);

    // Starvation: D and I held high, expect 4 D grants then 1 I grant, twice
    @(negedge clk1);
    i_req = 1'b1; i_addr = 10'd8;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd30; d_wdata = 32'hAA;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("starve_cnt_%0d", k), 32'(starve_cnt), exp_cnt[k]);
      chk($sformatf("starve_i_gnt_%0d", k), 32'(i_gnt), exp_ig[k]);
      chk($sformatf("starve_d_gnt_%0d", k), 32'(d_gnt), 32'(1 - exp_ig[k]));
      @(negedge clk1);
    end

    // Halt rises while the last fetch is returning; loader writes addr 100
    halted = 1'b1;
    l_req = 1'b1; l_we = 1'b1; l_addr = 10'd100; l_wdata = 32'hFC00_0000;
    d_we = 1'b0;
    #1;
    chk("halt_old_i_rvalid", 32'(i_rvalid), 1);
    chk("halt_old_i_rdata", i_rdata, 32'h2222_0008);
    chk("halt_l_gnt", 32'(l_gnt), 1);
    chk("halt_i_gnt", 32'(i_gnt), 0);
    chk("halt_d_gnt", 32'(d_gnt), 0);
    chk("halt_mem_we", 32'(mem_we), 1);
    chk("halt_mem_addr", 32'(mem_addr), 100);
    chk("halt_mem_wdata", mem_wdata, 32'hFC00_0000);
    @(negedge clk1);
    l_we = 1'b0;
    #1;
    chk("lrd_l_gnt", 32'(l_gnt), 1);
    chk("lrd_mem_we", 32'(mem_we), 0);
    chk("lrd_l_rvalid", 32'(l_rvalid), 0);
    chk("lrd_i_rvalid", 32'(i_rvalid), 0);
    chk("lrd_starve_hold", 32'(starve_cnt), 0);
    @(negedge clk1);
    idle(); halted = 1'b0;
    #1;
    chk("lrd2_l_rvalid", 32'(l_rvalid), 1);
    chk("lrd2_l_rdata", l_rdata, 32'hFC00_0000);
    chk("lrd2_i_rvalid", 32'(i_rvalid), 0);

    // Back-to-back: D load addr 7 then I fetch addr 8
    @(negedge clk1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd7;
    #1;
    chk("b2b_d_gnt", 32'(d_gnt), 1);
    @(negedge clk1);
    d_req = 1'b0; i_req = 1'b1; i_addr = 10'd8;
    #1;
    chk("b2b_i_gnt", 32'(i_gnt), 1);
    chk("b2b_d_rvalid", 32'(d_rvalid), 1);
    chk("b2b_d_rdata", d_rdata, 32'h1111_0007);
    chk("b2b_i_rvalid_early", 32'(i_rvalid), 0);
    @(negedge clk1);
    idle();
    #1;
    chk("b2b_i_rvalid", 32'(i_rvalid), 1);
    chk("b2b_i_rdata", i_rdata, 32'h2222_0008);
    chk("b2b_d_rvalid_late", 32'(d_rvalid), 0);

    // Reset mid-read: grant fetch at N, reset at N+1 with requests pending
    @(negedge clk1);
    i_req = 1'b1; i_addr = 10'd5;
    #1;
    chk("rmr_i_gnt", 32'(i_gnt), 1);
    @(negedge clk1);
    rst = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 10'd40;
    #1;
    chk("rmr_i_rvalid", 32'(i_rvalid), 0);
    chk("rmr_i_gnt_rst", 32'(i_gnt), 0);
    chk("rmr_d_gnt_rst", 32'(d_gnt), 0);
    chk("rmr_mem_en_rst", 32'(mem_en), 0);
    @(negedge clk1);
    rst = 1'b0;
    #1;
    chk("rmr_starve_after", 32'(starve_cnt), 0);
    chk("rmr_i_rvalid_after", 32'(i_rvalid), 0);
    chk("rmr_d_gnt_after", 32'(d_gnt), 1);
    @(negedge clk1);
    idle();
    @(negedge clk1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
